// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle for the iterative multiply/divide unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed/unsigned multiply and restoring divide; optional MULT_DIV_DIV_ZERO_EXC_EN
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  mult_div_unit_if.slave s_md
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t             r_state;
  state_t             w_next;

  // operands as sampled at start; kept for the whole operation
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a_in;
  logic [WIDTH-1:0]   r_b_in;

  // iteration datapath: r_acc is the partial product high half / partial remainder,
  // r_mq is the multiplier being shifted out / dividend shifted out and quotient shifted in
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_is_div;
  logic               w_signed;
  logic               w_b_zero;
  logic               w_dz_exc;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_mul_acc;
  logic [WIDTH:0]     w_shift;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_b_zero = (r_b_in == '0);

`ifdef MULT_DIV_DIV_ZERO_EXC_EN
  // divide by zero is flagged and short-circuits straight out of PREP
  assign w_dz_exc = w_is_div & w_b_zero;
`else
  assign w_dz_exc = 1'b0;
`endif

  // magnitudes and signs used by the unsigned core
  assign w_a_neg = w_signed & r_a_in[WIDTH-1];
  assign w_b_neg = w_signed & r_b_in[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~r_a_in + 1'b1) : r_a_in;
  assign w_b_mag = w_b_neg ? (~r_b_in + 1'b1) : r_b_in;

  // multiply step: conditional add of the multiplicand, then shift the pair right
  assign w_sum     = r_acc + {1'b0, r_b};
  assign w_mul_acc = r_mq[0] ? w_sum : r_acc;

  // divide step: shift in next dividend bit, subtract divisor if it fits
  assign w_shift = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
  assign w_q_bit = (w_shift >= {1'b0, r_b});

  // final sign correction
  assign w_prod     = {r_acc[WIDTH-1:0], r_mq};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo      = r_neg_q ? (~r_mq + 1'b1) : r_mq;
  assign w_rem      = r_neg_r ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (s_md.start) w_next = PREP;
      PREP: w_next = w_dz_exc ? IDLE : RUN;
      RUN:  if (r_cnt == CW'(1)) w_next = FIX;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // operand capture, iteration datapath and result registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_op       <= '0;
      r_a_in     <= '0;
      r_b_in     <= '0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_b        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (s_md.start) begin
            r_op   <= s_md.op;
            r_a_in <= s_md.a;
            r_b_in <= s_md.b;
          end
        end
        PREP: begin
          r_acc   <= '0;
          r_mq    <= w_a_mag;
          r_b     <= w_b_mag;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= CW'(WIDTH);
          if (w_dz_exc) begin
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_is_div) begin
            r_acc <= w_q_bit ? (w_shift - {1'b0, r_b}) : w_shift;
            r_mq  <= {r_mq[WIDTH-2:0], w_q_bit};
          end else begin
            r_acc <= {1'b0, w_mul_acc[WIDTH:1]};
            r_mq  <= {w_mul_acc[0], r_mq[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (w_is_div && w_b_zero) begin
            // zero divisor without the exception: fixed all-ones quotient, dividend as remainder
            r_hi <= r_a_in;
            r_lo <= '1;
          end else if (w_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign s_md.hi       = r_hi;
  assign s_md.lo       = r_lo;
  assign s_md.busy     = (r_state != IDLE);
  assign s_md.done     = r_done;
  assign s_md.div_zero = r_div_zero;

endmodule
